zpulse_frame_reader: RTL and testbench

ZPULSE_FRAME_READER -- requirements
Module: zpulse_frame_reader

---
 rtl/zpulse_frame_reader.sv | 102 ++++++++++
 tb/tb_zpulse_frame_reader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/zpulse_frame_reader.sv
// zpulse_frame_reader: frames BCD pulse-count snapshots as "C<8 digits>\r\n" ASCII byte stream.
// Optional ZPC_LEADZERO_BLANK_EN replaces leading zero digits (except digit0) with spaces.
module zpulse_frame_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        iDataUpdate,
    input  logic [31:0] iPulseCounter_LCD,
    output logic [7:0]  oByte,
    output logic        oByteValid,
    input  logic        iByteReady,
    output logic        oBusy,
    output logic [7:0]  oDropCnt,
    output logic        oBcdErr
);
    typedef enum logic [2:0] {IDLE, HDR, DIGIT, CR, LF} state_t;
    state_t state, state_nx;
    logic [31:0] mem [2];
    logic        wp, rp;
    logic [1:0]  cnt;
    logic        cap_v;
    logic [31:0] cap_d;
    logic [31:0] frame;
    logic [2:0]  idx;
    logic        xfer, pop, push;
    logic [3:0]  dig;
    logic [7:0]  dig_byte;
    assign oByteValid = state != IDLE;
    assign xfer = oByteValid && iByteReady;
    // a FIFO slot stays occupied until its frame has fully left, so the in-flight frame counts toward full
    assign pop = state == LF && xfer;
    assign push = cap_v && (cnt != 2'd2 || pop);
    assign oBusy = state != IDLE || cnt != 2'd0 || cap_v;
    assign dig = frame[{idx, 2'b00} +: 4];
`ifdef ZPC_LEADZERO_BLANK_EN
    assign dig_byte = (idx != 3'd0 && (frame >> {idx, 2'b00}) == 32'd0) ? 8'h20 :
                      (dig > 4'd9) ? 8'h3F : {4'h3, dig};
`else
    assign dig_byte = (dig > 4'd9) ? 8'h3F : {4'h3, dig};
`endif
    always_comb begin
        state_nx = state;
        oByte = 8'h00;
        case (state)
            IDLE:  state_nx = (cnt != 2'd0) ? HDR : IDLE;
            HDR: begin
                oByte = 8'h43;
                state_nx = xfer ? DIGIT : HDR;
            end
            DIGIT: begin
                oByte = dig_byte;
                state_nx = (xfer && idx == 3'd0) ? CR : DIGIT;
            end
            CR: begin
                oByte = 8'h0D;
                state_nx = xfer ? LF : CR;
            end
            LF: begin
                oByte = 8'h0A;
                state_nx = xfer ? IDLE : LF;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mem[0] <= '0;
            mem[1] <= '0;
            wp <= 1'b0;
            rp <= 1'b0;
            cnt <= 2'd0;
            cap_v <= 1'b0;
            cap_d <= '0;
            frame <= '0;
            idx <= 3'd7;
            oDropCnt <= 8'd0;
            oBcdErr <= 1'b0;
        end else begin
            state <= state_nx;
            cap_v <= en && iDataUpdate;
            cap_d <= iPulseCounter_LCD;
            if (push) begin
                mem[wp] <= cap_d;
                wp <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            if (cap_v && !push && oDropCnt != 8'hFF)
                oDropCnt <= oDropCnt + 8'd1;
            if (state == IDLE && cnt != 2'd0) begin
                frame <= mem[rp];
                idx <= 3'd7;
            end
            if (state == DIGIT && xfer)
                idx <= idx - 3'd1;
            if (state == DIGIT && dig > 4'd9)
                oBcdErr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_zpulse_frame_reader.sv
// tb_zpulse_frame_reader: directed self-checking bench for zpulse_frame_reader.
module tb_zpulse_frame_reader;
    logic        clk = 1'b0;
    logic        rst, en, iDataUpdate, iByteReady;
    logic [31:0] iPulseCounter_LCD;
    logic [7:0]  oByte, oDropCnt;
    logic        oByteValid, oBusy, oBcdErr;
    int          n_err = 0;
    int          n_checks = 0;
`ifdef ZPC_LEADZERO_BLANK_EN
    localparam logic [87:0] F12345 = 88'h43_20_20_20_31_32_33_34_35_0D_0A;
    localparam logic [87:0] FA009  = 88'h43_20_20_20_20_3F_30_30_39_0D_0A;
    localparam logic [87:0] F1     = 88'h43_20_20_20_20_20_20_20_31_0D_0A;
`else
    localparam logic [87:0] F12345 = 88'h43_30_30_30_31_32_33_34_35_0D_0A;
    localparam logic [87:0] FA009  = 88'h43_30_30_30_30_3F_30_30_39_0D_0A;
    localparam logic [87:0] F1     = 88'h43_30_30_30_30_30_30_30_31_0D_0A;
`endif
    localparam logic [87:0] F9876  = 88'h43_39_38_37_36_35_34_33_32_0D_0A;

    zpulse_frame_reader dut (
        .clk(clk), .rst(rst), .en(en), .iDataUpdate(iDataUpdate),
        .iPulseCounter_LCD(iPulseCounter_LCD), .oByte(oByte), .oByteValid(oByteValid),
        .iByteReady(iByteReady), .oBusy(oBusy), .oDropCnt(oDropCnt), .oBcdErr(oBcdErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_check(input string tag, input logic [87:0] e);
        for (int i = 0; i < 11; i++) begin
            chk(tag, {31'd0, oByteValid}, 32'd1);
            chk(tag, {24'd0, oByte}, {24'd0, e[87-8*i -: 8]});
            tick();
        end
    endtask

    task automatic strobe(input logic [31:0] d);
        iDataUpdate = 1'b1;
        iPulseCounter_LCD = d;
        tick();
        iDataUpdate = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; iDataUpdate = 1'b0; iByteReady = 1'b0; iPulseCounter_LCD = '0;
        tick();
        tick();
        chk("rst_valid", {31'd0, oByteValid}, 32'd0);
        chk("rst_byte", {24'd0, oByte}, 32'd0);
        chk("rst_busy", {31'd0, oBusy}, 32'd0);
        chk("rst_drop", {24'd0, oDropCnt}, 32'd0);
        chk("rst_bcd", {31'd0, oBcdErr}, 32'd0);
        // basic frame, capture on first edge after release, latency N+2
        rst = 1'b0;
        iByteReady = 1'b1;
        strobe(32'h0001_2345);
        chk("lat_n", {31'd0, oByteValid}, 32'd0);
        chk("lat_busy", {31'd0, oBusy}, 32'd1);
        tick();
        chk("lat_n1", {31'd0, oByteValid}, 32'd0);
        tick();
        frame_check("frame_12345", F12345);
        chk("end_valid", {31'd0, oByteValid}, 32'd0);
        chk("end_busy", {31'd0, oBusy}, 32'd0);
        chk("no_bcd", {31'd0, oBcdErr}, 32'd0);
        // non-BCD digit
        strobe(32'h0000_A009);
        tick();
        tick();
        frame_check("frame_a009", FA009);
        chk("bcd_sticky", {31'd0, oBcdErr}, 32'd1);
        tick();
        chk("bcd_sticky2", {31'd0, oBcdErr}, 32'd1);
        // three consecutive strobes while stalled: third is dropped
        iByteReady = 1'b0;
        strobe(32'h0000_0001);
        strobe(32'h9876_5432);
        strobe(32'h1111_1111);
        tick();
        chk("drop1", {24'd0, oDropCnt}, 32'd1);
        chk("drop_busy", {31'd0, oBusy}, 32'd1);
        chk("stall_byte", {24'd0, oByte}, 32'h43);
        tick();
        chk("stall_byte2", {24'd0, oByte}, 32'h43);
        iByteReady = 1'b1;
        frame_check("frame_a", F1);
        chk("gap_valid", {31'd0, oByteValid}, 32'd0);
        chk("gap_busy", {31'd0, oBusy}, 32'd1);
        tick();
        frame_check("frame_b", F9876);
        chk("after_b_valid", {31'd0, oByteValid}, 32'd0);
        chk("after_b_busy", {31'd0, oBusy}, 32'd0);
        // ready toggling: bytes hold while stalled
        strobe(32'h0001_2345);
        tick();
        tick();
        for (int i = 0; i < 11; i++) begin
            iByteReady = 1'b0;
            chk("tog_byte", {24'd0, oByte}, {24'd0, F12345[87-8*i -: 8]});
            tick();
            chk("tog_hold", {24'd0, oByte}, {24'd0, F12345[87-8*i -: 8]});
            chk("tog_valid", {31'd0, oByteValid}, 32'd1);
            iByteReady = 1'b1;
            tick();
        end
        chk("tog_end", {31'd0, oByteValid}, 32'd0);
        // reset after the 4th byte
        strobe(32'h0001_2345);
        tick();
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_byte", {24'd0, oByte}, 32'h31);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, oByteValid}, 32'd0);
        chk("mid_rst_byte", {24'd0, oByte}, 32'd0);
        chk("mid_rst_drop", {24'd0, oDropCnt}, 32'd0);
        chk("mid_rst_bcd", {31'd0, oBcdErr}, 32'd0);
        chk("mid_rst_busy", {31'd0, oBusy}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("no_resume", {31'd0, oByteValid}, 32'd0);
        strobe(32'h9876_5432);
        tick();
        tick();
        frame_check("post_rst", F9876);
        // en low blocks capture
        en = 1'b0;
        iDataUpdate = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        iDataUpdate = 1'b0;
        chk("en0_valid", {31'd0, oByteValid}, 32'd0);
        chk("en0_busy", {31'd0, oBusy}, 32'd0);
        // saturating drop counter
        en = 1'b1;
        iByteReady = 1'b0;
        iPulseCounter_LCD = 32'h0001_2345;
        iDataUpdate = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        iDataUpdate = 1'b0;
        tick();
        chk("drop_sat", {24'd0, oDropCnt}, 32'd255);
        // en low does not abort the frame or flush the FIFO
        en = 1'b0;
        iByteReady = 1'b1;
        frame_check("en0_frame1", F12345);
        chk("en0_gap", {31'd0, oByteValid}, 32'd0);
        tick();
        frame_check("en0_frame2", F12345);
        chk("final_busy", {31'd0, oBusy}, 32'd0);
        chk("final_drop", {24'd0, oDropCnt}, 32'd255);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
